// File: rtl/multi_event_timer.sv
// -----------------------------------------------------------------------------
// multi_event_timer
//
// Purpose:
//   NUM_CH independent countdown timers that share one slow tick enable (for
//   example a 30 Hz frame strobe). Each channel is loaded from its own
//   run-time period. It counts down once per qualifying tick, and it pulses
//   rise for one clk cycle when a tick arrives while the counter is already 0.
//   In periodic mode the channel then reloads and keeps running. In one-shot
//   mode it returns to IDLE.
//
// Ports:
//   clk        in   system clock
//   resetN     in   asynchronous active-low reset
//   tick       in   slow-rate enable, one clk cycle wide
//   pause      in   global freeze; ticks are ignored while high
//   start      in   [NUM_CH]        per-channel start/restart (loads period)
//   stop       in   [NUM_CH]        per-channel abort (highest priority)
//   periodic   in   [NUM_CH]        1 = auto-reload, 0 = one-shot
//   period     in   [NUM_CH*CNT_W]  channel i at [i*CNT_W +: CNT_W]
//   rise       out  [NUM_CH]        one-cycle expiry pulse per channel
//   rise_any   out  OR of all rise bits, aligned with rise
//   busy       out  [NUM_CH]        channel is in RUN
//   remaining  out  [NUM_CH*CNT_W]  current counter value, same packing
// -----------------------------------------------------------------------------
module multi_event_timer #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      tick,
  input  logic                      pause,
  input  logic [NUM_CH-1:0]         start,
  input  logic [NUM_CH-1:0]         stop,
  input  logic [NUM_CH-1:0]         periodic,
  input  logic [NUM_CH*CNT_W-1:0]   period,
  output logic [NUM_CH-1:0]         rise,
  output logic                      rise_any,
  output logic [NUM_CH-1:0]         busy,
  output logic [NUM_CH*CNT_W-1:0]   remaining
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // A tick counts for a channel only when it arrives unpaused.
  logic tick_ok;
  assign tick_ok = tick & ~pause;

  // Per-channel expiry decision for this cycle. It is also used to register
  // rise_any, so that rise_any lands in the same cycle as the rise bits.
  logic [NUM_CH-1:0] expire_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_t           state_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic             rise_reg;
      logic [CNT_W-1:0] period_ch;

      assign period_ch = period[gi*CNT_W +: CNT_W];

      // stop and start both take priority over expiry. A start in the same
      // cycle as a tick swallows that tick.
      assign expire_vec[gi] = (state_reg == RUN) && tick_ok &&
                              (cnt_reg == '0) && !stop[gi] && !start[gi];

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          rise_reg  <= 1'b0;
        end else begin
          rise_reg <= 1'b0;
          if (stop[gi]) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (start[gi]) begin
            state_reg <= RUN;
            cnt_reg   <= period_ch;
          end else if ((state_reg == RUN) && tick_ok) begin
            if (cnt_reg == '0) begin
              rise_reg <= 1'b1;
              // The mode is sampled at the moment of expiry.
              if (periodic[gi]) begin
                cnt_reg <= period_ch;
              end else begin
                state_reg <= IDLE;
              end
            end else begin
              cnt_reg <= cnt_reg - 1'b1;
            end
          end
        end
      end

      assign rise[gi]                       = rise_reg;
      assign busy[gi]                       = (state_reg == RUN);
      assign remaining[gi*CNT_W +: CNT_W]   = cnt_reg;
    end
  endgenerate

  logic rise_any_reg;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rise_any_reg <= 1'b0;
    end else begin
      rise_any_reg <= |expire_vec;
    end
  end

  assign rise_any = rise_any_reg;

endmodule
